// File: rtl/vga_text_renderer.sv
// vga_text_renderer
// Three-stage, strobe-gated text-mode pixel pipeline for an 80x30 grid of
// 8x16 character cells.
//   S0: character RAM address from the sampled x/y.
//   S1: font ROM address from the returned character code, and latch of the
//       colour indices.
//   S2: font bit selection and palette lookup.
// The syncs and the active flag travel alongside the pixel so that they stay
// aligned with the colour.
// Optional feature: define VGA_TEXT_CURSOR_EN to add a blinking underline
// cursor. This adds the i_cursor_x/i_cursor_y ports and a frame counter.
module vga_text_renderer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_active,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  output logic [11:0] o_char_addr,
  input  logic [15:0] i_char_data,
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [6:0]  i_cursor_x,
  input  logic [4:0]  i_cursor_y,
`endif
  output logic        o_rd_en,
  output logic        o_hs,
  output logic        o_vs,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b
);

  // Cell address = row*80 + col, built from shifts so no multiplier is needed.
  // The largest legal value is 29*80+79 = 2399, which fits in 12 bits.
  function automatic logic [11:0] f_cell_addr(input logic [4:0] row,
                                              input logic [6:0] col);
    logic [11:0] w_row;
    w_row = {7'd0, row};
    return (w_row << 6) + (w_row << 4) + {5'd0, col};
  endfunction

  // One colour channel: the channel bit selects on/off, and I selects the
  // bright level.
  function automatic logic [3:0] f_chan(input logic on, input logic bright);
    if (on) return bright ? 4'hF : 4'hA;
    else    return bright ? 4'h5 : 4'h0;
  endfunction

  // Fixed 16-entry palette. The index bits are {I,R,G,B}.
  function automatic logic [11:0] f_palette(input logic [3:0] idx);
    return {f_chan(idx[2], idx[3]), f_chan(idx[1], idx[3]), f_chan(idx[0], idx[3])};
  endfunction

  // Bit 7 of the font row is the leftmost pixel of the cell.
  function automatic logic f_font_bit(input logic [7:0] row, input logic [2:0] sel);
    logic [2:0] w_pos;
    w_pos = 3'd7 - sel;
    return row[w_pos];
  endfunction

  // S0 state
  logic [11:0] r_char_addr_p0;
  logic [3:0]  r_row_p0;
  logic [2:0]  r_col_p0;
  logic        r_hs_p0, r_vs_p0, r_act_p0;
  // S1 state
  logic [11:0] r_font_addr_p1;
  logic [3:0]  r_fg_p1, r_bg_p1;
  logic [2:0]  r_col_p1;
  logic        r_hs_p1, r_vs_p1, r_act_p1;
  // S2 state
  logic [11:0] r_rgb_p2;
  logic        r_hs_p2, r_vs_p2, r_act_p2;

  logic        w_font_bit;
  logic        w_pix;
  logic [3:0]  w_idx;

  assign o_rd_en = i_pix_stb;

`ifdef VGA_TEXT_CURSOR_EN
  logic       r_cur_p0, r_cur_p1;
  logic [5:0] r_frame;
  logic       w_cur_hit;

  // The cursor is an underline. It covers the bottom two rows (14 and 15)
  // of the selected cell.
  assign w_cur_hit = (i_x[9:3] == i_cursor_x) && (i_y[8:4] == i_cursor_y) &&
                     (i_y[3:1] == 3'b111);

  // Cursor hit flag travels with the pixel through S0 and S1
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cur_p0 <= 1'b0;
      r_cur_p1 <= 1'b0;
    end else if (i_pix_stb) begin
      r_cur_p0 <= w_cur_hit;
      r_cur_p1 <= r_cur_p0;
    end
  end

  // Frame counter: count falling edges of the fully delayed vsync. The edge
  // is seen when the value shifting into o_vs is low while o_vs is still high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_frame <= 6'd0;
    end else if (i_pix_stb && r_vs_p2 && !r_vs_p1) begin
      r_frame <= r_frame + 6'd1;
    end
  end
`endif

  // S0: register the character address, and carry the in-cell position and
  // the syncs forward
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_char_addr_p0 <= 12'd0;
      r_row_p0       <= 4'd0;
      r_col_p0       <= 3'd0;
      r_hs_p0        <= 1'b1;
      r_vs_p0        <= 1'b1;
      r_act_p0       <= 1'b0;
    end else if (i_pix_stb) begin
      r_char_addr_p0 <= f_cell_addr(i_y[8:4], i_x[9:3]);
      r_row_p0       <= i_y[3:0];
      r_col_p0       <= i_x[2:0];
      r_hs_p0        <= i_hs;
      r_vs_p0        <= i_vs;
      r_act_p0       <= i_active;
    end
  end

  // S1: form the font address from the character code, and latch the
  // colour indices
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_font_addr_p1 <= 12'd0;
      r_fg_p1        <= 4'd0;
      r_bg_p1        <= 4'd0;
      r_col_p1       <= 3'd0;
      r_hs_p1        <= 1'b1;
      r_vs_p1        <= 1'b1;
      r_act_p1       <= 1'b0;
    end else if (i_pix_stb) begin
      r_font_addr_p1 <= {i_char_data[7:0], r_row_p0};
      r_fg_p1        <= i_char_data[11:8];
      r_bg_p1        <= i_char_data[15:12];
      r_col_p1       <= r_col_p0;
      r_hs_p1        <= r_hs_p0;
      r_vs_p1        <= r_vs_p0;
      r_act_p1       <= r_act_p0;
    end
  end

  // Pixel bit selection, with the optional cursor override during the
  // blink-on phase
  always_comb begin
    w_font_bit = f_font_bit(i_font_data, r_col_p1);
`ifdef VGA_TEXT_CURSOR_EN
    w_pix      = w_font_bit | (r_cur_p1 & r_frame[5]);
`else
    w_pix      = w_font_bit;
`endif
    w_idx      = w_pix ? r_fg_p1 : r_bg_p1;
  end

  // S2: register the palette colour and the final sync/active delay stage
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rgb_p2 <= 12'd0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_act_p2 <= 1'b0;
    end else if (i_pix_stb) begin
      r_rgb_p2 <= f_palette(w_idx);
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_act_p2 <= r_act_p1;
    end
  end

  assign o_char_addr = r_char_addr_p0;
  assign o_font_addr = r_font_addr_p1;
  assign o_hs        = r_hs_p2;
  assign o_vs        = r_vs_p2;
  // Blanking: the colour is forced to black whenever the delayed active
  // flag is low
  assign o_r         = r_act_p2 ? r_rgb_p2[11:8] : 4'h0;
  assign o_g         = r_act_p2 ? r_rgb_p2[7:4]  : 4'h0;
  assign o_b         = r_act_p2 ? r_rgb_p2[3:0]  : 4'h0;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Testbench for vga_text_renderer. Vectors are replayed one per strobe, and
// expected colour/sync values are queued and compared three strobes later.
module tb_vga_text_renderer;

  logic        i_clk, i_rst, i_pix_stb, i_hs, i_vs, i_active;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic [11:0] o_char_addr, o_font_addr;
  logic [15:0] i_char_data;
  logic [7:0]  i_font_data;
  logic        o_rd_en, o_hs, o_vs;
  logic [3:0]  o_r, o_g, o_b;
`ifdef VGA_TEXT_CURSOR_EN
  logic [6:0]  i_cursor_x;
  logic [4:0]  i_cursor_y;
`endif

  vga_text_renderer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
    .i_hs(i_hs), .i_vs(i_vs), .i_active(i_active),
    .i_x(i_x), .i_y(i_y),
    .o_char_addr(o_char_addr), .i_char_data(i_char_data),
    .o_font_addr(o_font_addr), .i_font_data(i_font_data),
`ifdef VGA_TEXT_CURSOR_EN
    .i_cursor_x(i_cursor_x), .i_cursor_y(i_cursor_y),
`endif
    .o_rd_en(o_rd_en), .o_hs(o_hs), .o_vs(o_vs),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        act, hs, vs;
    logic [15:0] cd;
    logic [7:0]  fd;
    logic [11:0] ca, fa, rgb;
  } vec_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs, vs;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] m_pal(input logic [3:0] idx);
    logic [3:0] on_lvl, off_lvl;
    on_lvl  = idx[3] ? 4'hF : 4'hA;
    off_lvl = idx[3] ? 4'h5 : 4'h0;
    return {idx[2] ? on_lvl : off_lvl, idx[1] ? on_lvl : off_lvl,
            idx[0] ? on_lvl : off_lvl};
  endfunction

  function automatic vec_t mk(input logic [9:0] x, input logic [8:0] y,
                              input logic act, input logic hs, input logic vs,
                              input logic [15:0] cd, input logic [7:0] fd,
                              input logic [11:0] ca, input logic [11:0] fa,
                              input logic [11:0] rgb);
    vec_t v;
    v.x = x; v.y = y; v.act = act; v.hs = hs; v.vs = vs;
    v.cd = cd; v.fd = fd; v.ca = ca; v.fa = fa; v.rgb = rgb;
    return v;
  endfunction

  // Reference model: derives the addresses and colour from the cell layout
  function automatic vec_t mk_model(input logic [9:0] x, input logic [8:0] y,
                                    input logic act, input logic hs, input logic vs,
                                    input logic [15:0] cd, input logic [7:0] fd);
    int          sel;
    logic        bitv;
    logic [11:0] ca;
    sel  = 7 - int'(x % 8);
    bitv = fd[sel];
    ca   = 12'((int'(y) / 16) * 80 + int'(x) / 8);
    return mk(x, y, act, hs, vs, cd, fd, ca, {cd[7:0], y[3:0]},
              act ? m_pal(bitv ? cd[11:8] : cd[15:12]) : 12'h000);
  endfunction

  function automatic logic [63:0] snapshot();
    return {26'd0, o_r, o_g, o_b, o_hs, o_vs, o_char_addr, o_font_addr};
  endfunction

  task automatic load_table();
    vq.push_back(mk(10'd639, 9'd479, 1, 1, 1, 16'h1E41, 8'h80, 12'd2399, 12'h41F, 12'h00A));
    vq.push_back(mk(10'd8,   9'd16,  1, 1, 1, 16'h1E41, 8'h80, 12'd81,   12'h410, 12'hFF5));
    vq.push_back(mk(10'd0,   9'd15,  1, 1, 1, 16'h1E41, 8'h80, 12'd0,    12'h41F, 12'hFF5));
    vq.push_back(mk(10'd1,   9'd15,  1, 1, 1, 16'h1E41, 8'h80, 12'd0,    12'h41F, 12'h00A));
    vq.push_back(mk(10'd0,   9'd0,   0, 0, 1, 16'h1E41, 8'hFF, 12'd0,    12'h410, 12'h000));
    vq.push_back(mk(10'd1,   9'd0,   0, 0, 1, 16'h1E41, 8'hFF, 12'd0,    12'h410, 12'h000));
    vq.push_back(mk(10'd2,   9'd0,   1, 1, 1, 16'h7C00, 8'h20, 12'd0,    12'h000, 12'hF55));
    vq.push_back(mk(10'd3,   9'd0,   1, 1, 1, 16'h7C00, 8'h20, 12'd0,    12'h000, 12'hAAA));
    vq.push_back(mk(10'd320, 9'd240, 1, 1, 0, 16'h2A99, 8'h7F, 12'd1240, 12'h990, 12'h0A0));
    vq.push_back(mk(10'd327, 9'd255, 1, 1, 0, 16'h2A99, 8'h01, 12'd1240, 12'h99F, 12'h5F5));
    vq.push_back(mk(10'd632, 9'd464, 1, 1, 1, 16'hF0FF, 8'h00, 12'd2399, 12'hFF0, 12'hFFF));
    vq.push_back(mk(10'd0,   9'd0,   1, 1, 1, 16'h0F00, 8'hFF, 12'd0,    12'h000, 12'hFFF));
  endtask

  // Replay vq, one vector per strobe, with `gap` idle clocks between strobes.
  // The memories are modelled by feeding each vector's char data one strobe
  // after its sample, and its font data two strobes after.
  task automatic run_seq(input int gap);
    vec_t        v;
    exp_t        e, g;
    logic [63:0] snap;
    int          n;
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    sb.delete();
    sb.push_back(e);
    sb.push_back(e);
    vq.push_back(mk_model(10'd0, 9'd0, 0, 1, 1, 16'h0, 8'h0));
    vq.push_back(mk_model(10'd0, 9'd0, 0, 1, 1, 16'h0, 8'h0));
    n = vq.size();
    for (int k = 0; k < n; k++) begin
      v = vq[k];
      i_x = v.x; i_y = v.y; i_active = v.act; i_hs = v.hs; i_vs = v.vs;
      i_char_data = 16'h0;
      i_font_data = 8'h0;
      if (k >= 1) i_char_data = vq[k-1].cd;
      if (k >= 2) i_font_data = vq[k-2].fd;
      e.rgb = v.rgb; e.hs = v.hs; e.vs = v.vs;
      sb.push_back(e);
      i_pix_stb = 1'b1;
      #1;
      chk("rd_en", o_rd_en, 1'b1);
      @(posedge i_clk); #1;
      i_pix_stb = 1'b0;
      chk("char_addr", o_char_addr, v.ca);
      if (k >= 1) chk("font_addr", o_font_addr, vq[k-1].fa);
      if (sb.size() >= 3) begin
        g = sb.pop_front();
        chk("rgb", {o_r, o_g, o_b}, g.rgb);
        chk("hs", o_hs, g.hs);
        chk("vs", o_vs, g.vs);
      end
      snap = snapshot();
      for (int j = 0; j < gap; j++) begin
        i_x = 10'($urandom_range(0, 639)); i_y = 9'($urandom_range(0, 479));
        i_hs = 1'($urandom); i_vs = 1'($urandom); i_active = 1'($urandom);
        i_char_data = 16'($urandom); i_font_data = 8'($urandom);
        @(posedge i_clk); #1;
        chk("hold", snapshot(), snap);
      end
    end
    vq.delete();
  endtask

  initial begin
    i_rst = 1'b0; i_pix_stb = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_active = 1'b1;
    i_x = 10'd5; i_y = 9'd5; i_char_data = 16'hFFFF; i_font_data = 8'hFF;
`ifdef VGA_TEXT_CURSOR_EN
    i_cursor_x = 7'd127; i_cursor_y = 5'd31;
`endif
    // Reset held low with strobes running
    i_pix_stb = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    chk("rst_hs", o_hs, 1'b1);
    chk("rst_vs", o_vs, 1'b1);
    chk("rst_rgb", {o_r, o_g, o_b}, 12'h000);
    chk("rst_char_addr", o_char_addr, 12'd0);
    chk("rst_font_addr", o_font_addr, 12'd0);
    i_pix_stb = 1'b0;
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Directed table, with a strobe on every clock
    load_table();
    run_seq(0);

    // Random vectors checked against the model
    for (int i = 0; i < 40; i++)
      vq.push_back(mk_model(10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
                            1'($urandom), 1'($urandom), 1'($urandom),
                            16'($urandom), 8'($urandom)));
    run_seq(0);

    // Same table with a strobe every 4th clock; outputs must hold in between
    load_table();
    run_seq(3);

    // Asynchronous reset mid-line discards the in-flight pixels
    i_x = 10'd639; i_y = 9'd479; i_active = 1'b1; i_hs = 1'b0; i_vs = 1'b0;
    i_char_data = 16'hFE41; i_font_data = 8'hFF; i_pix_stb = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("pre_rst_char_addr", o_char_addr, 12'd2399);
    chk("pre_rst_hs", o_hs, 1'b0);
    #2 i_rst = 1'b0;
    #1;
    chk("async_rst_char_addr", o_char_addr, 12'd0);
    chk("async_rst_font_addr", o_font_addr, 12'd0);
    chk("async_rst_hs", o_hs, 1'b1);
    chk("async_rst_vs", o_vs, 1'b1);
    chk("async_rst_rgb", {o_r, o_g, o_b}, 12'h000);
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b1;
    i_pix_stb = 1'b0;
    @(posedge i_clk); #1;
    load_table();
    run_seq(0);

`ifdef VGA_TEXT_CURSOR_EN
    // Cursor at cell (2,1): start from a fresh reset so that frame count = 0
    i_rst = 1'b0;
    #3 i_rst = 1'b1;
    i_cursor_x = 7'd2; i_cursor_y = 5'd1;
    @(posedge i_clk); #1;
    vq.push_back(mk(10'd16, 9'd30, 1, 1, 1, 16'h1E41, 8'h00, 12'd82, 12'h41E, 12'h00A));
    vq.push_back(mk(10'd16, 9'd29, 1, 1, 1, 16'h1E41, 8'h00, 12'd82, 12'h41D, 12'h00A));
    run_seq(0);
    for (int f = 0; f < 32; f++) begin
      vq.push_back(mk_model(10'd0, 9'd0, 0, 1, 0, 16'h0, 8'h0));
      vq.push_back(mk_model(10'd0, 9'd0, 0, 1, 1, 16'h0, 8'h0));
    end
    vq.push_back(mk_model(10'd0, 9'd0, 0, 1, 1, 16'h0, 8'h0));
    run_seq(0);
    vq.push_back(mk(10'd16, 9'd30, 1, 1, 1, 16'h1E41, 8'h00, 12'd82, 12'h41E, 12'hFF5));
    vq.push_back(mk(10'd16, 9'd29, 1, 1, 1, 16'h1E41, 8'h00, 12'd82, 12'h41D, 12'h00A));
    vq.push_back(mk(10'd23, 9'd31, 1, 1, 1, 16'h1E41, 8'h00, 12'd82, 12'h41F, 12'hFF5));
    vq.push_back(mk(10'd24, 9'd30, 1, 1, 1, 16'h1E41, 8'h00, 12'd83, 12'h41E, 12'h00A));
    run_seq(0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
VGA_TEXT_RENDERER -- requirements
Module: vga_text_renderer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports (name  direction  width  meaning):
- i_clk  in  1  base clock
- i_rst  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel strobe; the pipeline advances only when it is high
- i_hs, i_vs  in  1 each  active-low syncs from the timing generator
- i_active  in  1  high during active pixels
- i_x  in  10  pixel x, 0..639
- i_y  in  9  pixel y, 0..479
- o_char_addr  out  12  character RAM address
- i_char_data  in  16  [7:0] code, [11:8] fg index, [15:12] bg index
- o_font_addr  out  12  font ROM address {code, row[3:0]}
- i_font_data  in  8  font row; bit 7 is the leftmost pixel
- o_rd_en  out  1  memory read enable; equals i_pix_stb
- o_hs, o_vs  out  1 each  delayed syncs
- o_r, o_g, o_b  out  4 each  pixel colour

Function
REQ-003 Text grid SHALL be 80x30 cells of 8x16 pixels.
REQ-004 The character RAM and font ROM SHALL have synchronous reads: the address is sampled when o_rd_en is high, and data SHALL be valid by the next i_pix_stb.
REQ-005 Stage S0 (strobe n) SHALL register o_char_addr = y[8:4]*80 + x[9:3], computed as (y[8:4]<<6)+(y[8:4]<<4)+x[9:3]; the range is 0..2399 in 12 bits, with no overflow.
REQ-006 Stage S1 (strobe n+1) SHALL:
- register o_font_addr = {i_char_data[7:0], y[3:0]}
- latch the fg and bg indices
- carry x[2:0] forward.
REQ-007 Stage S2 (strobe n+2) SHALL register a pixel bit = i_font_data[7 - x[2:0]] and drive fg colour if the bit is 1, else bg colour.
REQ-008 RGB output latency SHALL be exactly 3 strobes after the x/y sample.
- i_hs, i_vs and i_active SHALL travel through a matching 3-stage delay so that sync and colour stay aligned.
REQ-009 The palette SHALL be fixed, with index bits {I,R,G,B}.
- A channel bit of 1 gives 4'hF if I is set, else 4'hA.
- A channel bit of 0 gives 4'h5 if I is set, else 4'h0.
REQ-010 o_r/o_g/o_b SHALL be 0 whenever the delayed active signal is low, regardless of memory data.
REQ-011 Without i_pix_stb, every register SHALL hold its value; outputs SHALL be stable between strobes.
REQ-012 Edge case, back-to-back strobes (every clock): the block SHALL operate correctly.
REQ-013 Edge case, i_x/i_y wrap (639 to 0, 479 to 0): the block SHALL need no special handling; addresses follow the inputs.

Reset
REQ-014 On i_rst low, without waiting for a clock edge, the block SHALL set:
- all pipeline registers, o_char_addr, o_font_addr and RGB to 0
- o_hs = o_vs = 1 (inactive)
- delayed active = 0.
REQ-015 Reset asserted mid-line SHALL discard in-flight pixels; after release, the first valid RGB SHALL appear at the 3rd strobe.

Configuration
REQ-016 Macro VGA_TEXT_CURSOR_EN SHALL add the blinking cursor feature:
- ports i_cursor_x (7 bits) and i_cursor_y (5 bits)
- a 6-bit frame counter that increments on each falling edge of delayed i_vs; the blink phase is counter bit 5
- when the cell equals the cursor, the blink phase is 1 and row[3:0] >= 14, the pixel bit SHALL be forced to 1.
REQ-017 Without VGA_TEXT_CURSOR_EN, the cursor ports and counter SHALL be absent, and the output SHALL be identical to the macro-enabled build with the blink phase held at 0.

Verification
REQ-018 Reset: hold i_rst low with strobes running -> o_hs=o_vs=1, RGB=0, o_char_addr=0.
REQ-019 Address mapping: x=639, y=479 -> o_char_addr=2399; x=8, y=16 -> o_char_addr=81; x=0, y=15, code 0x41 -> o_font_addr=0x41F.
REQ-020 Pixel render: i_char_data=0x1E41 and i_font_data=0x80 at x=0 (active) -> RGB=F,F,5 (index E) exactly 3 strobes later; at x=1 -> RGB=0,0,A (index 1).
REQ-021 Blanking/sync: i_active low with font data 0xFF -> RGB=0; an i_hs pulse is reproduced on o_hs 3 strobes later with the same width.
REQ-022 Strobe gating: i_pix_stb asserted every 4th clock -> outputs change only on the clock following a strobe; results match the every-clock run.
REQ-023 Cursor (macro on): cursor=(2,1), 32 frames elapsed, pixel x=16, y=30, font 0x00 -> fg colour; at frame 0, or at row 13 -> bg colour.
